// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and writeback
// control strobes for a simple load/store core, plus a retired-instruction counter.
module control_fsm #(
    parameter logic [1:0] RESET_PC_SRC = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [4:0]  func,
    input  logic        flag_z,
    input  logic        flag_s,
    input  logic        flag_c,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        flag_write,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_BR    = 6'd5;
    localparam logic [5:0] OP_BLTZ  = 6'd6;
    localparam logic [5:0] OP_BZ    = 6'd7;
    localparam logic [5:0] OP_BNZ   = 6'd8;
    localparam logic [5:0] OP_BL    = 6'd9;
    localparam logic [5:0] OP_BCY   = 6'd10;
    localparam logic [5:0] OP_BNCY  = 6'd11;
    localparam logic [5:0] OP_HALT  = 6'd63;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_CMP  = 4'd1;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_ABS   = 2'd1;
    localparam logic [1:0] PC_REL   = 2'd2;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_LINK  = 2'd2;

    logic [2:0]  state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [4:0]  func_q, func_d;
    logic [31:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            func_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            retired_q <= retired_d;
        end
    end

    // Next state; opcode/func are only looked at in DECODE, everything after uses the latched copy.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        func_d    = func_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ack) state_d = S_DECODE;
            S_DECODE: begin
                op_d   = opcode;
                func_d = func;
                case (opcode)
                    OP_RTYPE: state_d = func[4] ? S_TRAP : S_EXEC;
                    OP_ADDI, OP_COMPI, OP_LW, OP_SW, OP_BR, OP_BLTZ,
                    OP_BZ, OP_BNZ, OP_BL, OP_BCY, OP_BNCY:
                        state_d = S_EXEC;
                    OP_HALT: begin
                        state_d   = S_HALT;
                        retired_d = retired_q + 32'd1;
                    end
                    default:  state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE:                  state_d = func_q[4] ? S_TRAP : S_WB;
                    OP_ADDI, OP_COMPI, OP_BL:  state_d = S_WB;
                    OP_LW, OP_SW:              state_d = S_MEM;
                    OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY: begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 32'd1;
                    end
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (op_q == OP_SW) begin
                        state_d   = S_FETCH;
                        retired_d = retired_q + 32'd1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d   = S_FETCH;
                retired_d = retired_q + 32'd1;
            end
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        flag_write = 1'b0;
        pc_src     = PC_SEQ;
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        wb_sel     = WB_ALU;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE:  pc_src = RESET_PC_SRC;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        flag_write = ~func_q[4];
                        alu_op     = func_q[3:0];
                    end
                    OP_ADDI: begin
                        flag_write = 1'b1;
                        alu_src    = 1'b1;
                    end
                    OP_COMPI: begin
                        flag_write = 1'b1;
                        alu_src    = 1'b1;
                        alu_op     = ALU_CMP;
                    end
                    OP_LW, OP_SW: alu_src = 1'b1;
                    OP_BR, OP_BL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_ABS;
                    end
                    OP_BLTZ: begin pc_src = PC_REL; pc_write = flag_s;  end
                    OP_BZ:   begin pc_src = PC_REL; pc_write = flag_z;  end
                    OP_BNZ:  begin pc_src = PC_REL; pc_write = ~flag_z; end
                    OP_BCY:  begin pc_src = PC_REL; pc_write = flag_c;  end
                    OP_BNCY: begin pc_src = PC_REL; pc_write = ~flag_c; end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LW)      wb_sel = WB_MEM;
                else if (op_q == OP_BL) wb_sel = WB_LINK;
            end
            S_HALT:  halted  = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
